// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and a word-addressed data memory.
// Sub-word stores are performed as read-modify-write. Load data is extended before it is returned.
module lsu_mem_master #(
   parameter bit ERR_ON_MISALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_write,
   output logic        mem_read,
   output logic [31:0] address,
   output logic [31:0] write_data,
   input  logic [31:0] read_data,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]  r_state;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdq;
   logic        r_err;

   logic        w_accept;
   logic        w_illegal;
   logic        w_misal;
   logic        w_err;
   logic [31:0] w_align_addr;
   logic [31:0] w_wmerge;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;

   // Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is high only in IDLE.
   assign w_accept  = req_valid && (r_state == S_IDLE);
   assign w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                      (req_we && req_funct3[2]);
   assign w_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign w_err     = w_illegal || (ERR_ON_MISALIGN && w_misal);

   // Aligning at latch time makes later lane selection use the aligned bits.
   always_comb begin
      w_align_addr = req_addr;
      if (req_funct3[1:0] == 2'b01)
         w_align_addr = {req_addr[31:1], 1'b0};
      else if (req_funct3[1:0] == 2'b10)
         w_align_addr = {req_addr[31:2], 2'b00};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= 32'h0;
         r_wdata  <= 32'h0;
         r_rdq    <= 32'h0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_addr   <= w_align_addr;
                  r_wdata  <= req_wdata;
                  r_err    <= w_err;
                  if (w_err)
                     r_state <= S_RESP;
                  else if (req_we && (req_funct3[1:0] == 2'b10))
                     r_state <= S_WR;
                  else
                     r_state <= S_RD;
               end
            end
            S_RD: begin
               r_rdq   <= read_data;
               r_state <= r_we ? S_WR : S_RESP;
            end
            S_WR:    r_state <= S_RESP;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_wmerge = r_rdq;
      case (r_funct3[1:0])
         2'b00: begin
            case (r_addr[1:0])
               2'b00:   w_wmerge[7:0]   = r_wdata[7:0];
               2'b01:   w_wmerge[15:8]  = r_wdata[7:0];
               2'b10:   w_wmerge[23:16] = r_wdata[7:0];
               default: w_wmerge[31:24] = r_wdata[7:0];
            endcase
         end
         2'b01: begin
            if (r_addr[1])
               w_wmerge[31:16] = r_wdata[15:0];
            else
               w_wmerge[15:0]  = r_wdata[15:0];
         end
         default: w_wmerge = r_wdata;
      endcase
   end

   always_comb begin
      case (r_addr[1:0])
         2'b00:   w_byte = r_rdq[7:0];
         2'b01:   w_byte = r_rdq[15:8];
         2'b10:   w_byte = r_rdq[23:16];
         default: w_byte = r_rdq[31:24];
      endcase
      w_half = r_addr[1] ? r_rdq[31:16] : r_rdq[15:0];
      case (r_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b010:  w_load = r_rdq;
         3'b100:  w_load = {24'h0, w_byte};
         3'b101:  w_load = {16'h0, w_half};
         default: w_load = 32'h0;
      endcase
   end

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_err   = resp_valid && r_err;
   assign resp_rdata = (resp_valid && !r_err && !r_we) ? w_load : 32'h0;
   assign mem_read   = (r_state == S_RD);
   assign mem_write  = (r_state == S_WR);
   assign address    = (mem_read || mem_write) ? {r_addr[31:2], 2'b00} : 32'h0;
   assign write_data = mem_write ? w_wmerge : 32'h0;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: one strict-alignment instance and one auto-aligning instance,
// each with its own small word memory answering read_data combinationally.
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_init = 1'b1;
   logic        req_valid_a = 1'b0;
   logic        req_valid_b = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;

   logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_write, a_mem_read;
   logic [31:0] a_resp_rdata, a_address, a_write_data, a_read_data;
   logic [1:0]  a_dbg_state;
   logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_write, b_mem_read;
   logic [31:0] b_resp_rdata, b_address, b_write_data, b_read_data;
   logic [1:0]  b_dbg_state;

   logic [31:0] mem_a [0:15];
   logic [31:0] mem_b [0:15];

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   lsu_mem_master #(.ERR_ON_MISALIGN(1'b1)) dut_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_a), .req_ready(a_req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
      .mem_write(a_mem_write), .mem_read(a_mem_read), .address(a_address),
      .write_data(a_write_data), .read_data(a_read_data), .dbg_state(a_dbg_state)
   );

   lsu_mem_master #(.ERR_ON_MISALIGN(1'b0)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_b), .req_ready(b_req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
      .mem_write(b_mem_write), .mem_read(b_mem_read), .address(b_address),
      .write_data(b_write_data), .read_data(b_read_data), .dbg_state(b_dbg_state)
   );

   assign a_read_data = mem_a[a_address[5:2]];
   assign b_read_data = mem_b[b_address[5:2]];

   always_ff @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) begin
            mem_a[i] <= 32'h0;
            mem_b[i] <= 32'h0;
         end
         mem_a[4] <= 32'h8899AABB;
         mem_b[4] <= 32'h11223344;
      end else begin
         if (a_mem_write) mem_a[a_address[5:2]] <= a_write_data;
         if (b_mem_write) mem_b[b_address[5:2]] <= b_write_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
   endtask

   // Presents one request for a single cycle; returns just after the accepting edge (start of N+1).
   task automatic issue(input bit to_b, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(posedge clk); #1;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      if (to_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
      @(posedge clk); #1;
      req_valid_a = 1'b0; req_valid_b = 1'b0;
   endtask

   task automatic load_a(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp);
      issue(1'b0, 1'b0, f3, addr, 32'h0);
      @(negedge clk);
      check({tag, " rd mem_read"}, {31'h0, a_mem_read}, 32'h1);
      check({tag, " rd address"}, a_address, {addr[31:2], 2'b00});
      @(negedge clk);
      check({tag, " resp_valid"}, {31'h0, a_resp_valid}, 32'h1);
      check({tag, " rdata"}, a_resp_rdata, exp);
      check({tag, " err"}, {31'h0, a_resp_err}, 32'h0);
      @(negedge clk);
   endtask

   task automatic error_a(input string tag, input bit we, input logic [2:0] f3, input logic [31:0] addr);
      issue(1'b0, we, f3, addr, 32'hFFFFFFFF);
      @(negedge clk);
      check({tag, " resp_valid"}, {31'h0, a_resp_valid}, 32'h1);
      check({tag, " err"}, {31'h0, a_resp_err}, 32'h1);
      check({tag, " rdata"}, a_resp_rdata, 32'h0);
      check({tag, " mem strobes"}, {30'h0, a_mem_read, a_mem_write}, 32'h0);
      @(negedge clk);
      check({tag, " ready after"}, {31'h0, a_req_ready}, 32'h1);
      check({tag, " mem strobes after"}, {30'h0, a_mem_read, a_mem_write}, 32'h0);
   endtask

   task automatic sub_store_a(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_wd);
      issue(1'b0, 1'b1, f3, addr, wdata);
      @(negedge clk);
      check({tag, " rd mem_read"}, {30'h0, a_mem_read, a_mem_write}, 32'h2);
      @(negedge clk);
      check({tag, " wr strobes"}, {30'h0, a_mem_read, a_mem_write}, 32'h1);
      check({tag, " write_data"}, a_write_data, exp_wd);
      check({tag, " wr address"}, a_address, {addr[31:2], 2'b00});
      @(negedge clk);
      check({tag, " resp_valid"}, {31'h0, a_resp_valid}, 32'h1);
      check({tag, " rdata"}, a_resp_rdata, 32'h0);
      check({tag, " resp strobes"}, {30'h0, a_mem_read, a_mem_write}, 32'h0);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1; mem_init = 1'b0;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      check("rst ready", {31'h0, a_req_ready}, 32'h1);
      check("rst outs", {28'h0, a_resp_valid, a_resp_err, a_mem_read, a_mem_write}, 32'h0);
      check("rst address", a_address, 32'h0);
      check("rst write_data", a_write_data, 32'h0);
      check("rst rdata", a_resp_rdata, 32'h0);
      check("rst state", {30'h0, a_dbg_state}, 32'h0);

      // LW with explicit per-cycle checks
      issue(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
      @(negedge clk);
      check("lw N+1 mem_read", {31'h0, a_mem_read}, 32'h1);
      check("lw N+1 address", a_address, 32'h10);
      check("lw N+1 ready", {31'h0, a_req_ready}, 32'h0);
      check("lw N+1 resp", {31'h0, a_resp_valid}, 32'h0);
      check("lw N+1 state", {30'h0, a_dbg_state}, 32'h1);
      @(negedge clk);
      check("lw N+2 resp", {31'h0, a_resp_valid}, 32'h1);
      check("lw N+2 rdata", a_resp_rdata, 32'h8899AABB);
      check("lw N+2 err", {31'h0, a_resp_err}, 32'h0);
      check("lw N+2 mem_read", {31'h0, a_mem_read}, 32'h0);
      @(negedge clk);
      check("lw N+3 ready", {31'h0, a_req_ready}, 32'h1);
      check("lw N+3 resp", {31'h0, a_resp_valid}, 32'h0);
      check("lw N+3 rdata", a_resp_rdata, 32'h0);

      load_a("lb 13",  3'b000, 32'h13, 32'hFFFFFF88);
      load_a("lbu 13", 3'b100, 32'h13, 32'h00000088);
      load_a("lh 12",  3'b001, 32'h12, 32'hFFFF8899);
      load_a("lhu 10", 3'b101, 32'h10, 32'h0000AABB);
      load_a("lb 10",  3'b000, 32'h10, 32'hFFFFFFBB);

      sub_store_a("sb 11", 3'b000, 32'h11, 32'h123456CC, 32'h8899CCBB);
      load_a("lw after sb", 3'b010, 32'h10, 32'h8899CCBB);
      sub_store_a("sh 12", 3'b001, 32'h12, 32'hDEAD1234, 32'h1234CCBB);
      load_a("lw after sh", 3'b010, 32'h10, 32'h1234CCBB);

      // SW goes straight to the write cycle
      issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D);
      @(negedge clk);
      check("sw N+1 strobes", {30'h0, a_mem_read, a_mem_write}, 32'h1);
      check("sw N+1 write_data", a_write_data, 32'hCAFEF00D);
      check("sw N+1 address", a_address, 32'h10);
      @(negedge clk);
      check("sw N+2 resp", {31'h0, a_resp_valid}, 32'h1);
      check("sw N+2 rdata", a_resp_rdata, 32'h0);
      @(negedge clk);
      load_a("lw after sw", 3'b010, 32'h10, 32'hCAFEF00D);

      error_a("err lw 12", 1'b0, 3'b010, 32'h12);
      error_a("err sh 11", 1'b1, 3'b001, 32'h11);
      error_a("err f3 011", 1'b0, 3'b011, 32'h10);
      error_a("err store f3 100", 1'b1, 3'b100, 32'h10);
      error_a("err f3 111", 1'b0, 3'b111, 32'h10);

      // SB aborted by a reset pulse taken at the end of its RD cycle
      issue(1'b0, 1'b1, 3'b000, 32'h10, 32'h000000EE);
      @(negedge clk);
      check("abort rd mem_read", {31'h0, a_mem_read}, 32'h1);
      reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      check("abort ready", {31'h0, a_req_ready}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         check("abort no write/resp", {30'h0, a_mem_write, a_resp_valid}, 32'h0);
         @(negedge clk);
      end
      check("abort mem intact", mem_a[4], 32'hCAFEF00D);
      load_a("lw after abort", 3'b010, 32'h10, 32'hCAFEF00D);

      // Back-to-back with req_valid held high
      @(posedge clk); #1;
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid_a = 1'b1;
      @(posedge clk); #1;
      req_funct3 = 3'b100; req_addr = 32'h10;
      @(negedge clk);
      check("b2b N+1 ready", {31'h0, a_req_ready}, 32'h0);
      @(negedge clk);
      check("b2b N+2 resp", {31'h0, a_resp_valid}, 32'h1);
      check("b2b N+2 rdata", a_resp_rdata, 32'hCAFEF00D);
      check("b2b N+2 ready", {31'h0, a_req_ready}, 32'h0);
      @(negedge clk);
      check("b2b N+3 ready", {31'h0, a_req_ready}, 32'h1);
      check("b2b N+3 quiet", {30'h0, a_resp_valid, a_mem_read}, 32'h0);
      @(posedge clk); #1; req_valid_a = 1'b0;
      @(negedge clk);
      check("b2b 2nd mem_read", {31'h0, a_mem_read}, 32'h1);
      @(negedge clk);
      check("b2b 2nd resp", {31'h0, a_resp_valid}, 32'h1);
      check("b2b 2nd rdata", a_resp_rdata, 32'h0000000D);
      @(negedge clk);

      // Auto-aligning instance
      issue(1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
      @(negedge clk);
      check("al lw 12 mem_read", {31'h0, b_mem_read}, 32'h1);
      check("al lw 12 address", b_address, 32'h10);
      @(negedge clk);
      check("al lw 12 resp", {30'h0, b_resp_valid, b_resp_err}, 32'h2);
      check("al lw 12 rdata", b_resp_rdata, 32'h11223344);
      @(negedge clk);
      issue(1'b1, 1'b0, 3'b001, 32'h13, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("al lh 13 resp", {30'h0, b_resp_valid, b_resp_err}, 32'h2);
      check("al lh 13 rdata", b_resp_rdata, 32'h00001122);
      @(negedge clk);
      issue(1'b1, 1'b1, 3'b001, 32'h11, 32'h0000BEEF);
      @(negedge clk);
      @(negedge clk);
      check("al sh 11 write", {31'h0, b_mem_write}, 32'h1);
      check("al sh 11 write_data", b_write_data, 32'h1122BEEF);
      @(negedge clk);
      check("al sh 11 resp", {30'h0, b_resp_valid, b_resp_err}, 32'h2);
      check("a idle during b", {30'h0, a_mem_read, a_mem_write}, 32'h0);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the core's execute stage and the word-addressed data memory.
- Accepts one load or store request at a time and drives the memory's mem_read/mem_write/address/write_data pins. The memory returns read_data combinationally.
- Byte and halfword stores are done as read-modify-write, because the memory only writes whole 32-bit words.
- Load data is extracted and sign- or zero-extended before being returned to the core.

Parameters:
- ERR_ON_MISALIGN, 1: 1 = misaligned access returns an error and touches no memory; 0 = low address bits are forced to alignment and the access proceeds.

Ports:
- clk  input  1  clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; only the low byte/half is used for SB/SH.
- resp_valid  output  1  single-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  illegal funct3 or misaligned access; valid with resp_valid.
- mem_write  output  1  memory write strobe.
- mem_read  output  1  memory read enable.
- address  output  32  word-aligned byte address {a[31:2],2'b00}.
- write_data  output  32  full word to write.
- read_data  input  32  combinational read data from memory.

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset: state=IDLE. All latched registers are 0. req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, address=0, write_data=0.
- IDLE
  - On accept, latch we, funct3, addr, wdata.
  - Error condition: funct3 in {011,110,111}, or a store with funct3 in {100,101}, or (ERR_ON_MISALIGN=1 and misaligned). Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0. On error: go to RESP with err=1.
  - Otherwise: LW/LH/LB/LHU/LBU go to RD; SB/SH go to RD; SW goes to WR.
- RD
  - mem_read=1, address driven from the latched address.
  - read_data is captured into rdq at the end of the cycle.
  - Next state: RESP for a load, WR for a store.
- WR
  - mem_write=1 for exactly one cycle.
  - SW: write_data=wdata.
  - SH: rdq with half addr[1] replaced by wdata[15:0].
  - SB: rdq with byte addr[1:0] replaced by wdata[7:0].
  - Next state: RESP.
- RESP
  - resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
  - Load data is taken from rdq: the byte lane is addr[1:0], the half lane is addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - resp_rdata and resp_err are 0 when resp_valid=0.
- Outside RD/WR: mem_read, mem_write, address and write_data are all 0.
- Latency (accept at cycle N, resp_valid asserted):
  - loads: N+2
  - SW: N+2
  - SB/SH: N+3
  - error: N+1
- req_ready is low from N+1 until the cycle after RESP. Peak throughput is one request per 3 cycles.
- Errors never assert mem_read or mem_write.
- Reset mid-operation: the next edge forces IDLE and no mem_write is issued afterwards. An in-flight SB/SH aborted in RD leaves memory unchanged, and no response is produced.
- With ERR_ON_MISALIGN=0, misaligned addresses are silently aligned down: a halfword access at address a uses a&~1, a word access uses a&~3. Lane selection then uses the aligned bits.

Test Plan:
- mem[0x10]=0x8899AABB; LW 0x10 -> mem_read=1 only at N+1 with address 0x10; resp_valid at N+2, resp_rdata=0x8899AABB, resp_err=0.
- LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
- SB 0x11, wdata 0x123456CC -> N+1 mem_read=1; N+2 mem_write=1, write_data=0x8899CCBB; resp at N+3 with rdata 0. A following LW 0x10 returns 0x8899CCBB.
- SH 0x12 wdata 0xDEAD1234 -> write_data 0x1234CCBB. SW 0x10 wdata 0xCAFEF00D -> no mem_read; mem_write at N+1; resp at N+2.
- LW 0x12, SH 0x11, and funct3=011 -> each gives resp_valid+resp_err at N+1, with mem_read and mem_write never high. With ERR_ON_MISALIGN=0, LW 0x12 reads word 0x10.
- SB issued, reset pulsed during RD -> no mem_write ever asserted; memory unchanged; no resp_valid; req_ready=1 on the first cycle after reset drops.
- req_valid held high with back-to-back requests -> the second request is accepted only on the cycle req_ready returns high, one cycle after the first resp_valid pulse.
